// File: rtl/field_pack_pkg.sv
// field_pack_pkg
// Shared definitions for the field packing arbiter:
//   - state_t          : controller state (COLLECT while gathering fields,
//                        FULL while the packed word waits for the consumer)
//   - DEF_N_REQ        : default number of requesters
//   - DEF_FIELD_W      : default width of one field
//   - DEF_FIELDS_PER_WORD : default number of fields per packed word
//   - calc_out_w()     : width of the packed word
package field_pack_pkg;

    localparam int DEF_N_REQ           = 4;
    localparam int DEF_FIELD_W         = 2;
    localparam int DEF_FIELDS_PER_WORD = 4;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    function automatic int calc_out_w(input int field_w, input int fields_per_word);
        return field_w * fields_per_word;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin priority rotator. The search for a
// requesting bit starts at index ptr and wraps modulo N; the first hit wins.
// Ports:
//   req     : request vector, one bit per requester
//   ptr     : index with highest priority this cycle
//   gnt     : one-hot-or-zero grant vector
//   gnt_idx : index of the granted requester (0 when nothing is granted)
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    // Walk the N candidates in priority order starting at ptr; the found
    // flag stops later candidates from overriding the first winner.
    always_comb begin
        int   idx;
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/field_pack_arbiter.sv
// field_pack_arbiter
// Round-robin controller that shares one packing word between N_REQ field
// producers. Accepted fields are shifted in from the LSB end, so the first
// field accepted ends up in the MSBs of the finished word. Once the word
// holds FIELDS_PER_WORD fields it is presented downstream and no further
// fields are accepted until the consumer takes it.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   req_valid  : per-requester field offer
//   req_data   : packed fields, requester i at [i*FIELD_W +: FIELD_W]
//   req_ready  : one-hot-or-zero grant back to the requesters
//   out_valid  : packed word available
//   out_data   : packed word, first accepted field in the MSBs
//   out_ready  : consumer accepts the word
//   fill       : number of fields currently held
module field_pack_arbiter
    import field_pack_pkg::*;
#(
    parameter int N_REQ           = DEF_N_REQ,
    parameter int FIELD_W         = DEF_FIELD_W,
    parameter int FIELDS_PER_WORD = DEF_FIELDS_PER_WORD,
    localparam int OUT_W          = calc_out_w(FIELD_W, FIELDS_PER_WORD),
    localparam int FILL_W         = $clog2(FIELDS_PER_WORD + 1),
    localparam int PTR_W          = $clog2(N_REQ)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*FIELD_W-1:0]   req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       out_valid,
    output logic [OUT_W-1:0]           out_data,
    input  logic                       out_ready,
    output logic [FILL_W-1:0]          fill
);

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [OUT_W-1:0]   word;
    logic [N_REQ-1:0]   gnt;
    logic [PTR_W-1:0]   gnt_idx;
    logic [FIELD_W-1:0] sel_data;
    logic               xfer;
    logic [PTR_W-1:0]   next_ptr;

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (PTR_W)
    ) u_rr_arbiter (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Grants are only exposed while collecting; rst_n gates them so that no
    // requester sees a grant while the block is held in reset.
    always_comb begin
        req_ready = '0;
        if (rst_n && state == COLLECT) begin
            req_ready = gnt;
        end
    end

    // Field of the granted requester, selected by the one-hot grant.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel_data = req_data[i*FIELD_W +: FIELD_W];
            end
        end
    end

    assign xfer = (state == COLLECT) && (|gnt);

    // Priority moves to the requester after the winner, wrapping at N_REQ.
    always_comb begin
        next_ptr = gnt_idx + PTR_W'(1);
        if (gnt_idx == PTR_W'(N_REQ - 1)) begin
            next_ptr = '0;
        end
    end

    // Controller state, rotation pointer, fill count and the word register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
            ptr   <= '0;
            fill  <= '0;
            word  <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (xfer) begin
                        word <= {word[OUT_W-FIELD_W-1:0], sel_data};
                        fill <= fill + FILL_W'(1);
                        ptr  <= next_ptr;
                        if (fill == FILL_W'(FIELDS_PER_WORD - 1)) begin
                            state <= FULL;
                        end
                    end
                end
                FULL: begin
                    // The word register is cleared so out_data reads zero
                    // between words; ptr keeps its place in the rotation.
                    if (out_ready) begin
                        state <= COLLECT;
                        fill  <= '0;
                        word  <= '0;
                    end
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

    assign out_valid = (state == FULL);
    assign out_data  = word;

endmodule

// File: tb/tb_field_pack_arbiter.sv
// tb_field_pack_arbiter
// Scoreboard bench for field_pack_arbiter with default parameters
// (4 requesters, 2-bit fields, 4 fields per 8-bit word). Stimulus pushes
// expected grant indices and expected packed words into queues; two monitor
// processes pop and compare on every grant and every output handshake.
module tb_field_pack_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_valid;
    logic [7:0] req_data;
    logic [3:0] req_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [2:0] fill;

    int checks   = 0;
    int failures = 0;

    int         grant_q[$];
    logic [7:0] word_q[$];

    field_pack_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .fill      (fill)
    );

    // 10 ns clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requester i's field goes to bits [2i+1:2i].
    function automatic logic [7:0] pack_data(input logic [1:0] d0, input logic [1:0] d1,
                                              input logic [1:0] d2, input logic [1:0] d3);
        return {d3, d2, d1, d0};
    endfunction

    // Advance to 1 ns after the next rising edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [7:0] data,
                                 input logic ready, input int cycles);
        req_valid = valid;
        req_data  = data;
        out_ready = ready;
        tick(cycles);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic pushGrants(input int a, input int b, input int c, input int d);
        grant_q.push_back(a);
        grant_q.push_back(b);
        grant_q.push_back(c);
        grant_q.push_back(d);
    endtask

    // Grant monitor: every observed grant must match the next expected index.
    initial begin
        int exp_idx;
        forever begin
            @(negedge clk);
            if (rst_n && (|req_ready)) begin
                checks++;
                if (grant_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL grant_unexpected actual=%b required=none", req_ready);
                end else begin
                    exp_idx = grant_q.pop_front();
                    if (req_ready !== (4'b0001 << exp_idx)) begin
                        failures++;
                        $display("[TB] FAIL grant actual=%b required=%b", req_ready,
                                 4'b0001 << exp_idx);
                    end
                end
            end
        end
    end

    // Word monitor: every output handshake must deliver the next expected word.
    initial begin
        logic [7:0] exp_word;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                checks++;
                if (word_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL word_unexpected actual=%h required=none", out_data);
                end else begin
                    exp_word = word_q.pop_front();
                    if (out_data !== exp_word || fill !== 3'd4) begin
                        failures++;
                        $display("[TB] FAIL word actual=%h/fill%0d required=%h/fill4",
                                 out_data, fill, exp_word);
                    end
                end
            end
        end
    end

    initial begin
        logic [1:0] sparse_vals [4];
        sparse_vals = '{2'd1, 2'd3, 2'd0, 2'd2};

        // Reset with requesters already valid: nothing may be granted.
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_data  = pack_data(2'd3, 2'd2, 2'd1, 2'd0);
        out_ready = 1'b1;
        tick(2);
        checkOutput("reset_req_ready", 32'(req_ready), 32'h0);
        checkOutput("reset_out_valid", 32'(out_valid), 32'h0);
        checkOutput("reset_out_data",  32'(out_data),  32'h0);
        checkOutput("reset_fill",      32'(fill),      32'h0);
        req_valid = 4'b0000;
        rst_n     = 1'b1;
        tick(1);

        // Basic pack: grants 0,1,2,3 -> 11_10_01_00.
        $display("[TB] basic pack");
        pushGrants(0, 1, 2, 3);
        word_q.push_back(8'hE4);
        applyStimulus(4'b1111, pack_data(2'd3, 2'd2, 2'd1, 2'd0), 1'b1, 4);
        req_valid = 4'b0000;
        checkOutput("basic_out_valid", 32'(out_valid), 32'h1);
        checkOutput("basic_out_data",  32'(out_data),  32'hE4);
        checkOutput("basic_fill",      32'(fill),      32'h4);
        tick(1);
        checkOutput("basic_drain_valid", 32'(out_valid), 32'h0);
        checkOutput("basic_drain_fill",  32'(fill),      32'h0);
        checkOutput("basic_drain_data",  32'(out_data),  32'h0);

        // Backpressure: requesters stay valid while FULL, nothing is granted.
        $display("[TB] backpressure");
        pushGrants(0, 1, 2, 3);
        word_q.push_back(8'hE4);
        applyStimulus(4'b1111, pack_data(2'd3, 2'd2, 2'd1, 2'd0), 1'b0, 4);
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp_out_data",  32'(out_data),  32'hE4);
            checkOutput("bp_req_ready", 32'(req_ready), 32'h0);
            checkOutput("bp_out_valid", 32'(out_valid), 32'h1);
            tick(1);
        end
        pushGrants(0, 1, 2, 3);
        word_q.push_back(8'hE4);
        applyStimulus(4'b1111, pack_data(2'd3, 2'd2, 2'd1, 2'd0), 1'b1, 1);
        checkOutput("bp_resume_valid",     32'(out_valid), 32'h0);
        checkOutput("bp_resume_fill",      32'(fill),      32'h0);
        checkOutput("bp_resume_req_ready", 32'(req_ready), 32'h1);
        tick(4);
        req_valid = 4'b0000;
        checkOutput("bp_second_fill", 32'(fill), 32'h4);
        tick(1);
        checkOutput("bp_second_drain", 32'(out_valid), 32'h0);

        // Rotation: only req 2, then all four -> 2,3,0,1,2,3,0,1.
        $display("[TB] rotation");
        pushGrants(2, 3, 0, 1);
        pushGrants(2, 3, 0, 1);
        word_q.push_back(8'h4E);
        word_q.push_back(8'h4E);
        applyStimulus(4'b0100, pack_data(2'd3, 2'd2, 2'd1, 2'd0), 1'b1, 1);
        checkOutput("rot_single_fill", 32'(fill), 32'h1);
        applyStimulus(4'b1111, pack_data(2'd3, 2'd2, 2'd1, 2'd0), 1'b1, 3);
        checkOutput("rot_first_data", 32'(out_data), 32'h4E);
        tick(5);
        req_valid = 4'b0000;
        checkOutput("rot_second_valid", 32'(out_valid), 32'h1);
        tick(1);

        // Sparse: req 1 valid one cycle in three, data 1,3,0,2 -> 01_11_00_10.
        $display("[TB] sparse");
        pushGrants(1, 1, 1, 1);
        word_q.push_back(8'h72);
        for (int p = 0; p < 4; p++) begin
            applyStimulus(4'b0010, pack_data(2'd0, sparse_vals[p], 2'd0, 2'd0), 1'b1, 1);
            checkOutput("sparse_fill_step", 32'(fill), 32'(p + 1));
            req_valid = 4'b0000;
            if (p < 3) begin
                tick(2);
                checkOutput("sparse_fill_hold", 32'(fill), 32'(p + 1));
            end
        end
        checkOutput("sparse_out_valid", 32'(out_valid), 32'h1);
        checkOutput("sparse_out_data",  32'(out_data),  32'h72);
        tick(1);

        // Reset mid-word: two fields taken, then reset discards them.
        $display("[TB] reset mid-word");
        grant_q.push_back(2);
        grant_q.push_back(3);
        applyStimulus(4'b1111, pack_data(2'd3, 2'd2, 2'd1, 2'd0), 1'b1, 2);
        checkOutput("midrst_fill_before", 32'(fill), 32'h2);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_fill",      32'(fill),      32'h0);
        checkOutput("midrst_out_valid", 32'(out_valid), 32'h0);
        checkOutput("midrst_out_data",  32'(out_data),  32'h0);
        checkOutput("midrst_req_ready", 32'(req_ready), 32'h0);
        @(posedge clk);
        #1;
        pushGrants(0, 1, 2, 3);
        word_q.push_back(8'hE4);
        rst_n = 1'b1;
        tick(4);
        req_valid = 4'b0000;
        checkOutput("midrst_word_data", 32'(out_data), 32'hE4);
        tick(2);

        checkOutput("grants_left", 32'(grant_q.size()), 32'h0);
        checkOutput("words_left",  32'(word_q.size()),  32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/field_pack_arbiter.md
# field_pack_arbiter

Round-robin controller for the bit-concatenation datapath. It shares one packing word between N_REQ requesters, each offering a FIELD_W-bit field over a valid/ready handshake. It concatenates the accepted fields MSB-first into an OUT_W-bit word and presents the word downstream under valid/ready backpressure. It sits between field producers and any consumer of packed words.

## Interface
- N_REQ, default 4: number of requesters; must be ≥ 2.
- FIELD_W, default 2: width of each field, in bits.
- FIELDS_PER_WORD, default 4: number of fields per packed word; must be ≥ 2.
- OUT_W, derived as FIELD_W*FIELDS_PER_WORD (8 by default); not overridable.
- clk, input, 1: the single clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- req_valid, input, N_REQ: requester i is offering a field.
- req_data, input, N_REQ*FIELD_W: field of requester i at bits [i*FIELD_W +: FIELD_W].
- req_ready, output, N_REQ: one-hot-or-zero grant; requester i transfers when req_valid[i] and req_ready[i] are both high.
- out_valid, output, 1: a packed word is available.
- out_data, output, OUT_W: the packed word; the first accepted field sits in the MSBs.
- out_ready, input, 1: the consumer accepts the word.
- fill, output, $clog2(FIELDS_PER_WORD+1): number of fields currently held.

## Operation
- States: COLLECT and FULL. Reset state is COLLECT with fill=0, pointer ptr=0, out_data=0 and out_valid=0.
- **COLLECT:**
  - The arbiter grants the first requester i with req_valid[i]=1, searching ptr, ptr+1, … mod N_REQ.
  - req_ready is combinational from req_valid and ptr, with at most one bit set.
  - On a transfer:
    - word <= {word[OUT_W-FIELD_W-1:0], req_data[i]}
    - fill <= fill+1
    - ptr <= (i+1) mod N_REQ
  - With no valid requester: req_ready=0 and no state change.
- **COLLECT → FULL** on the transfer that makes fill = FIELDS_PER_WORD.
- **FULL:**
  - req_ready=0 on all bits.
  - out_valid=1; out_data is held stable until the handshake completes.
- **FULL → COLLECT** on out_valid & out_ready:
  - fill <= 0
  - The word register is cleared to 0.
  - ptr is unchanged.
- **Fairness:** a continuously valid requester is granted within N_REQ transfers.
- **Boundary conditions:**
  - req_valid is all-ones: grants rotate strictly.
  - A requester may drop req_valid without a transfer, which is legal for requesters; the grant moves on.
  - out_ready held high before FULL has no effect.
  - There is no simultaneous collect-and-drain: the FULL cycle accepts nothing.
- **Reset mid-operation:** the partial word is discarded. All state returns to reset values immediately and asynchronously. req_ready is forced to 0 while rst_n=0.

## Timing
- A transfer in cycle t is reflected in fill and in the word at t+1.
- The final transfer in cycle t raises out_valid at t+1.
- A handshake in cycle t lowers out_valid at t+1; the next grant can occur at t+1.
- Maximum throughput is one word per FIELDS_PER_WORD+1 cycles (5 by default).
- req_ready has a combinational path from req_valid; requesters must not make req_valid depend on req_ready.
- Every output has a defined reset value:
  - out_valid=0
  - out_data=0
  - fill=0
  - req_ready=0

## Structure
- Package field_pack_pkg holds:
  - The state enum: COLLECT and FULL.
  - The default values of N_REQ, FIELD_W and FIELDS_PER_WORD.
  - A function computing OUT_W.
- Sub-module rr_arbiter (parameter N, input req[N], input ptr, output one-hot gnt, output gnt_idx) is the purely combinational priority rotator.
- Everything else lives in the top module: the FSM, ptr, fill and the word register.

## Test plan
- **Basic pack:** after reset, requesters 0..3 valid with data 3,2,1,0, out_ready=1. Required response:
  - Grants go to 0,1,2,3 in consecutive cycles.
  - out_valid=1 at cycle 5 with out_data=8'b11_10_01_00 and fill=4.
  - The next cycle shows out_valid=0 and fill=0.
- **Backpressure:** same stimulus with out_ready=0 for 10 cycles. Required response:
  - out_data stays 8'hE4 and req_ready stays 0 throughout.
  - Raising out_ready gives one handshake, then collection resumes.
- **Rotation:** only req 2 is valid, then all four. Required response:
  - Grant sequence is 2,3,0,1,2,3…
  - No requester is granted twice before every valid requester has been granted once.
- **Sparse requests:** req_valid pulses on req 1 every third cycle. Required response:
  - fill increments only on handshake cycles.
  - The word completes after the 4th accepted field.
- **Reset mid-word:** rst_n asserted low at fill=2 for one cycle. Required response:
  - fill=0, out_valid=0, out_data=0 and req_ready=0 during reset.
  - The next word packs only fields accepted after release.
